// File: rtl/fibonacci_seq.sv
// Iterative Fibonacci generator: F(n) for a registered index n, one addition per clock.
// Free-running; any change of n restarts the computation, F holds the last completed result.
module fibonacci_seq #(
  parameter int N_W = 4,
  parameter int F_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N_W-1:0] n,
  output logic [F_W-1:0] F,
  output logic           done
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [F_W-1:0] a;
  logic [F_W-1:0] b;
  logic [N_W-1:0] cnt;
  logic [N_W-1:0] n_q;

  // NOTE: every register here is state, so only non-blocking assignments are used;
  // blocking ones would let later statements see the new values within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      a     <= '0;
      b     <= F_W'(1);
      cnt   <= '0;
      n_q   <= '0;
      F     <= '0;
      done  <= 1'b0;
    end else begin
      n_q <= n;
      // A changed index wins over a completion that would land on this edge.
      if (state != LOAD && n != n_q) begin
        a     <= '0;
        b     <= F_W'(1);
        cnt   <= '0;
        done  <= 1'b0;
        state <= RUN;
      end else begin
        case (state)
          LOAD: begin
            a     <= '0;
            b     <= F_W'(1);
            cnt   <= '0;
            done  <= 1'b0;
            state <= RUN;
          end
          RUN: begin
            if (cnt == n_q) begin
              F     <= a;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              a   <= b;
              b   <= a + b;
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            done <= 1'b1;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_seq.sv
// Scoreboard bench for fibonacci_seq: stimulus queues expected (F, completion edge),
// a negedge monitor pops on every rising done and checks F holds otherwise.
module tb_fibonacci_seq;

  typedef struct {
    int f;
    int at_edge;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  n;
  logic [11:0] F;
  logic        done;

  int   edge_cnt = 0;
  int   compared = 0;
  int   failed   = 0;
  exp_t sb[$];

  int fib_tab [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

  fibonacci_seq #(.N_W(4), .F_W(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .n    (n),
    .F    (F),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", name, act, exp, $time, edge_cnt);
    end
  endtask

  // Drive n at a negedge; the next posedge captures it and completion is n+1 edges later.
  task automatic set_n(input int v, input bit expect_result);
    exp_t e;
    n = 4'(v);
    if (expect_result) begin
      e.f       = fib_tab[v];
      e.at_edge = edge_cnt + 1 + v + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    int left = budget;
    while (sb.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    if (sb.size() != 0) begin
      compared++;
      failed++;
      $display("FAIL done_timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  // Monitor: each rising done consumes one expected result; otherwise F must hold.
  int last_f    = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_f    = 0;
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL unexpected_done: F=%0d with no result expected (edge=%0d)", F, edge_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_f", int'(F), e.f);
          check("result_edge", edge_cnt, e.at_edge);
        end
        last_f = int'(F);
      end else begin
        check("f_hold", int'(F), last_f);
      end
      prev_done = done;
    end
  end

  initial begin
    // Reset with n=10 held: 55 expected on the 12th edge after release.
    rst_n = 1'b0;
    n     = 4'd10;
    #1;
    check("reset_f", int'(F), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_n(10, 1'b1);
    wait_done(40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stable_done", int'(done), 1);
      check("stable_f", int'(F), 55);
    end

    // n=15: largest index, no overflow.
    set_n(15, 1'b1);
    wait_done(40);

    // Fresh reset with n=0, then step to n=1.
    rst_n = 1'b0;
    n     = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_n(0, 1'b1);
    wait_done(20);
    @(negedge clk);
    set_n(1, 1'b1);
    @(negedge clk);
    check("restart_done_n1", int'(done), 0);
    wait_done(20);

    // Switch 10 -> 5 after four RUN edges; the abandoned 10 never completes.
    @(negedge clk);
    set_n(10, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_switch_done", int'(done), 0);
    set_n(5, 1'b1);
    @(negedge clk);
    check("switch_done", int'(done), 0);
    check("switch_f_held", int'(F), 1);
    wait_done(20);

    // Async reset mid-RUN with n=7: outputs clear without a clock edge.
    @(negedge clk);
    set_n(7, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_f", int'(F), 0);
    check("async_rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_n(7, 1'b1);
    wait_done(20);

    // Sweep 0..15, each held until its result arrives.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_n(i, 1'b1);
      wait_done(30);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
